shift_add_multiplier: RTL and testbench

- Multi-cycle unsigned 16x16 multiplier that consumes the combinational ADDER stage.
- Each iteration feeds ADDER with in0 = accumulator and in1 = shifted multiplicand, then registers ADDER's sum.
- Sits in the emulator ALU path; the MUL opcode uses it because a single-cycle multiply is too costly.
- Produces the low 16 bits of the product, an overflow flag, and a start/busy/done handshake.

---
 rtl/shift_add_multiplier.sv | 113 +++++++++++
 tb/tb_shift_add_multiplier.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned WIDTH x WIDTH shift-and-add multiplier.
// Returns the low WIDTH product bits, an overflow flag and a start/busy/done handshake.
module shift_add_multiplier #(
    parameter int unsigned WIDTH      = 16,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    count_q, count_d;
    logic             lost_q, lost_d;
    logic             ovf_q, ovf_d;

    // Combinational adder stage: wraps mod 2^WIDTH, carry recovered by compare.
    logic [WIDTH-1:0] sum;
    logic             carry;
    assign sum   = acc_q + a_q;
    assign carry = (sum < acc_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_d   = out_q;
        count_d = count_q;
        lost_d  = lost_q;
        ovf_d   = ovf_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = in0;
                    b_d     = in1;
                    acc_d   = '0;
                    count_d = '0;
                    lost_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (b_q[0]) begin
                    acc_d = sum;
                    if (carry || lost_q) ovf_d = 1'b1;
                end
                a_d     = a_q << 1;
                lost_d  = lost_q | a_q[WIDTH-1];
                b_d     = b_q >> 1;
                count_d = count_q + 1'b1;
                if ((count_q == CW'(WIDTH - 1)) || (EARLY_EXIT && (b_d == '0))) begin
                    state_d = DONE;
                    out_d   = acc_d;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            count_q <= '0;
            lost_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            count_q <= count_d;
            lost_q  <= lost_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out      = out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (early-exit and full-length instances).
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] in0 = '0;
    logic [15:0] in1 = '0;
    logic [15:0] out0, out1;
    logic        ovf0, ovf1, busy0, busy1, done0, done1;

    int checks = 0;
    int errors = 0;
    int ndone0 = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_fast (
        .clk(clk), .reset_n(reset_n), .start(start0), .in0(in0), .in1(in1),
        .out(out0), .overflow(ovf0), .busy(busy0), .done(done0)
    );

    shift_add_multiplier #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_full (
        .clk(clk), .reset_n(reset_n), .start(start1), .in0(in0), .in1(in1),
        .out(out1), .overflow(ovf1), .busy(busy1), .done(done1)
    );

    always @(negedge clk) if (done0) ndone0++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Latency = negedges counted after the accepting edge until done is seen.
    task automatic mul_test(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input bit slow, input int exp_lat,
                            input logic [15:0] exp_o, input logic exp_ov);
        int lat;
        logic [15:0] o;
        logic ov;
        lat = -1;
        o   = '0;
        ov  = 1'b0;
        @(negedge clk);
        in0 = a;
        in1 = b;
        if (slow) start1 = 1'b1; else start0 = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
            if (slow ? done1 : done0) begin
                lat = c;
                o   = slow ? out1 : out0;
                ov  = slow ? ovf1 : ovf0;
                break;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_out"}, {16'd0, o}, {16'd0, exp_o});
        chk({tag, "_ovf"}, {31'd0, ov}, {31'd0, exp_ov});
        @(negedge clk);
        chk({tag, "_busy_end"}, {31'd0, slow ? busy1 : busy0}, 32'd0);
    endtask

    initial begin
        int base;
        int lat;
        #1 reset_n = 1'b0;
        #10;
        chk("rst_out", {16'd0, out0}, 32'd0);
        chk("rst_ovf", {31'd0, ovf0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        mul_test("m100x200",   16'd100,   16'd200,   1'b0, 9,  16'd20000, 1'b0);
        mul_test("m100x200_f", 16'd100,   16'd200,   1'b1, 17, 16'd20000, 1'b0);
        mul_test("m2536x113_f",16'd2536,  16'd113,   1'b1, 17, 16'd24424, 1'b1);
        mul_test("m256x256",   16'd256,   16'd256,   1'b0, 10, 16'd0,     1'b1);
        mul_test("mFFFFx1",    16'hFFFF,  16'd1,     1'b0, 2,  16'd65535, 1'b0);
        mul_test("m1234x0",    16'd1234,  16'd0,     1'b0, 2,  16'd0,     1'b0);
        mul_test("m0xFFFF",    16'd0,     16'hFFFF,  1'b0, 17, 16'd0,     1'b0);

        // Handshake: restarts mid-RUN and during DONE must be ignored.
        base = ndone0;
        lat  = -1;
        @(negedge clk);
        in0 = 16'd2536;
        in1 = 16'd113;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        in0 = 16'd7;
        in1 = 16'd9;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int c = 4; c <= 40; c++) begin
            @(negedge clk);
            if (done0) begin
                lat = c;
                break;
            end
        end
        chk("hs_lat", lat, 8);
        chk("hs_out", {16'd0, out0}, 32'd24424);
        chk("hs_ovf", {31'd0, ovf0}, 32'd1);
        in0 = 16'd3;
        in1 = 16'd3;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("hs_busy_after", {31'd0, busy0}, 32'd0);
        repeat (5) @(negedge clk);
        chk("hs_hold_out", {16'd0, out0}, 32'd24424);
        chk("hs_hold_ovf", {31'd0, ovf0}, 32'd1);
        chk("hs_busy_idle", {31'd0, busy0}, 32'd0);
        chk("hs_one_done", ndone0 - base, 1);

        // Asynchronous reset three cycles into a run.
        @(negedge clk);
        in0 = 16'hFFFF;
        in1 = 16'hFFFF;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_busy", {31'd0, busy0}, 32'd1);
        chk("pre_rst_ovf", {31'd0, ovf0}, 32'd1);
        chk("pre_rst_out", {16'd0, out0}, 32'd24424);
        base = ndone0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out", {16'd0, out0}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
        chk("mid_rst_done", {31'd0, done0}, 32'd0);
        chk("mid_rst_ovf", {31'd0, ovf0}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("no_done_after_rst", ndone0 - base, 0);
        chk("idle_after_rst", {31'd0, busy0}, 32'd0);

        mul_test("m3x5", 16'd3, 16'd5, 1'b0, 4, 16'd15, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
